// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline sequencer for a 5-stage RV32 core (IF/ID/EX/MEM/WB).
//            Tracks a shadow tag pipeline for EX/MEM/WB and produces the
//            per-register enables/flushes, EX operand forwarding selects,
//            load-use stalls, redirect squashes and memory-wait freezes.
//            Owns no datapath state.
// Options  : define HAZARD_CTRL_PERF_EN to build the stall/flush/freeze
//            performance counters; otherwise they read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    localparam logic [1:0]        c_FWD_RF  = 2'b00;
    localparam logic [1:0]        c_FWD_MEM = 2'b01;
    localparam logic [1:0]        c_FWD_WB  = 2'b10;
    localparam logic [REG_AW-1:0] c_X0      = '0;

    // EX tag (full), MEM tag (no source regs), WB tag (no load flag needed)
    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    logic              mem_is_load_q, mem_is_load_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    logic w_freeze;
    logic w_redirect;
    logic w_load_use;
    logic w_ex_wr;
    logic w_mem_wr;
    logic w_wb_wr;

    // Event classification in priority order: freeze, redirect, load-use
    always_comb begin
        w_ex_wr    = ex_valid_q & ex_regwrite_q & (ex_rd_q != c_X0);
        w_mem_wr   = mem_valid_q & mem_regwrite_q & (mem_rd_q != c_X0);
        w_wb_wr    = wb_valid_q & wb_regwrite_q & (wb_rd_q != c_X0);
        w_freeze   = mem_req & ~mem_ready;
        w_redirect = ~w_freeze & ex_redirect;
        w_load_use = ~w_freeze & ~ex_redirect & id_valid & ex_is_load_q & w_ex_wr &
                     (((ex_rd_q == id_rs1) & id_use_rs1) |
                      ((ex_rd_q == id_rs2) & id_use_rs2));
    end

    // Register enables/flushes and forwarding selects
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        fwd_a       = c_FWD_RF;
        fwd_b       = c_FWD_RF;
        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            if (w_freeze) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end else if (w_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            // A load in MEM has no data yet; it is covered by the stall, then WB
            if (w_mem_wr & ~mem_is_load_q & (mem_rd_q == ex_rs1_q)) begin
                fwd_a = c_FWD_MEM;
            end else if (w_wb_wr & (wb_rd_q == ex_rs1_q)) begin
                fwd_a = c_FWD_WB;
            end
            if (w_mem_wr & ~mem_is_load_q & (mem_rd_q == ex_rs2_q)) begin
                fwd_b = c_FWD_MEM;
            end else if (w_wb_wr & (wb_rd_q == ex_rs2_q)) begin
                fwd_b = c_FWD_WB;
            end
        end
    end

    // Tag pipeline next state: hold on freeze, squash EX on redirect/stall
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rd_d        = ex_rd_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_is_load_d   = ex_is_load_q;
        mem_valid_d    = mem_valid_q;
        mem_rd_d       = mem_rd_q;
        mem_regwrite_d = mem_regwrite_q;
        mem_is_load_d  = mem_is_load_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_regwrite_d  = wb_regwrite_q;
        if (!w_freeze) begin
            wb_valid_d     = mem_valid_q;
            wb_rd_d        = mem_rd_q;
            wb_regwrite_d  = mem_regwrite_q;
            mem_valid_d    = ex_valid_q;
            mem_rd_d       = ex_rd_q;
            mem_regwrite_d = ex_regwrite_q;
            mem_is_load_d  = ex_is_load_q;
            if (w_redirect | w_load_use) begin
                // Squashed slot: all-zero tag so it can never match or forward
                ex_valid_d    = 1'b0;
                ex_rd_d       = '0;
                ex_rs1_d      = '0;
                ex_rs2_d      = '0;
                ex_regwrite_d = 1'b0;
                ex_is_load_d  = 1'b0;
            end else begin
                ex_valid_d    = id_valid;
                ex_rd_d       = id_rd;
                ex_rs1_d      = id_rs1;
                ex_rs2_d      = id_rs2;
                ex_regwrite_d = id_regwrite;
                ex_is_load_d  = id_is_load;
            end
        end
    end

    // Tag pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_is_load_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            mem_is_load_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_is_load_q   <= ex_is_load_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_is_load_q  <= mem_is_load_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] freeze_cnt_q;

    // Event counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (w_load_use) stall_cnt_q  <= stall_cnt_q + 1'b1;
            if (w_redirect) flush_cnt_q  <= flush_cnt_q + 1'b1;
            if (w_freeze)   freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed pipeline scenarios
//            with literal expectations, then randomized traffic compared
//            every cycle against a behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              ex_redirect, mem_req, mem_ready;
    logic              pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic              ex_mem_en, mem_wb_en;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, freeze_cnt;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       rw;
        bit       ld;
    } tag_t;

    tag_t        m_ex, m_mem, m_wb;
    logic [31:0] m_stall, m_flush, m_freeze;
    bit          model_ok = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit produces(input tag_t t, input logic [4:0] r);
        return t.v && t.rw && (t.rd == r) && (r != 5'd0);
    endfunction

    // 0 reset, 1 freeze, 2 redirect, 3 load-use, 4 run
    function automatic int cur_mode();
        if (reset) return 0;
        if (mem_req && !mem_ready) return 1;
        if (ex_redirect) return 2;
        if (id_valid && m_ex.ld &&
            ((id_use_rs1 && produces(m_ex, id_rs1)) || (id_use_rs2 && produces(m_ex, id_rs2))))
            return 3;
        return 4;
    endfunction

    // Youngest completed producer supplies the operand
    function automatic logic [1:0] src_for(input logic [4:0] r);
        if (produces(m_mem, r) && !m_mem.ld) return 2'b01;
        if (produces(m_wb, r)) return 2'b10;
        return 2'b00;
    endfunction

    // Advance the model on each active edge
    always @(posedge clk) begin
        int m;
        m = cur_mode();
        if (m == 0) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_stall = 0; m_flush = 0; m_freeze = 0;
            model_ok = 1'b1;
        end else if (m == 1) begin
            m_freeze = m_freeze + 1;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (m == 2 || m == 3) m_ex = '0;
            else m_ex = '{v: id_valid, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                          rw: id_regwrite, ld: id_is_load};
            if (m == 2) m_flush = m_flush + 1;
            if (m == 3) m_stall = m_stall + 1;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        int         m;
        logic [6:0] ctl;
        if (model_ok) begin
            m = cur_mode();
            // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
            case (m)
                0:       ctl = 7'b0010100;
                1:       ctl = 7'b0000000;
                2:       ctl = 7'b1111111;
                3:       ctl = 7'b0001111;
                default: ctl = 7'b1101011;
            endcase
            chk("ctl", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                        ex_mem_en, mem_wb_en}, {25'd0, ctl});
            chk("fwd_a", {30'd0, fwd_a}, {30'd0, (m == 0) ? 2'b00 : src_for(m_ex.rs1)});
            chk("fwd_b", {30'd0, fwd_b}, {30'd0, (m == 0) ? 2'b00 : src_for(m_ex.rs2)});
            chk("stall_cnt",  stall_cnt,  PERF ? m_stall  : 32'd0);
            chk("flush_cnt",  flush_cnt,  PERF ? m_flush  : 32'd0);
            chk("freeze_cnt", freeze_cnt, PERF ? m_freeze : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit [4:0] rd, input bit u1, input bit u2,
                          input bit rw, input bit ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_is_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        nop();
        @(negedge clk);
        chk("reset pc_en", {31'd0, pc_en}, 32'd0);
        chk("reset flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset enables", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en,
                                   id_ex_flush, ex_mem_en, mem_wb_en}, 32'h6B);
        tick();

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward
        set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
        set_id(1, 5, 3, 6, 1, 1, 1, 0); tick();
        nop(); @(negedge clk);
        chk("t1 fwd_a mem", {30'd0, fwd_a}, 32'd1);
        tick(); drain();
        // same pair with one gap -> WB forward
        set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
        nop(); tick();
        set_id(1, 5, 3, 6, 1, 1, 1, 0); tick();
        nop(); @(negedge clk);
        chk("t1 fwd_a wb", {30'd0, fwd_a}, 32'd2);
        tick(); drain();

        // lw x7 ; add x8,x7,x7 -> one stall, then WB forward on both operands
        set_id(1, 1, 0, 7, 1, 0, 1, 1); tick();
        set_id(1, 7, 7, 8, 1, 1, 1, 0);
        @(negedge clk);
        chk("t2 stall", {29'd0, pc_en, if_id_en, id_ex_flush}, 32'd1);
        tick();
        @(negedge clk);
        chk("t2 release", {31'd0, pc_en}, 32'd1);
        tick();
        nop(); @(negedge clk);
        chk("t2 fwd", {28'd0, fwd_a, fwd_b}, 32'hA);
        tick(); drain();

        // lw x0 ; add x1,x0,x0 -> no stall, no forward
        set_id(1, 1, 0, 0, 1, 0, 1, 1); tick();
        set_id(1, 0, 0, 1, 1, 1, 1, 0);
        @(negedge clk);
        chk("t5 x0 no stall", {31'd0, pc_en}, 32'd1);
        tick(); nop(); @(negedge clk);
        chk("t5 x0 no fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        tick(); drain();
        // redirect coincident with load-use -> redirect wins
        set_id(1, 1, 0, 7, 1, 0, 1, 1); tick();
        set_id(1, 7, 7, 8, 1, 1, 1, 0); ex_redirect = 1'b1;
        @(negedge clk);
        chk("t5 redirect wins", {29'd0, pc_en, if_id_en, if_id_flush}, 32'd7);
        tick(); ex_redirect = 1'b0; drain();

        // reset asserted during a load-use stall
        set_id(1, 1, 0, 7, 1, 0, 1, 1); tick();
        set_id(1, 7, 7, 8, 1, 1, 1, 0); reset = 1'b1;
        tick(); reset = 1'b0; nop();
        @(negedge clk);
        chk("t6 pc_en", {31'd0, pc_en}, 32'd1);
        chk("t6 fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        chk("t6 counters", stall_cnt | flush_cnt | freeze_cnt, 32'd0);
        tick();

        // add x5 ; sw x5 then three memory-wait cycles
        set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
        set_id(1, 5, 6, 0, 1, 1, 0, 0); tick();
        nop(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4 frozen", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en,
                              id_ex_flush, ex_mem_en, mem_wb_en}, 32'd0);
            chk("t4 tags held", {30'd0, fwd_a}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t4 freeze_cnt", freeze_cnt, PERF ? 32'd3 : 32'd0);
        chk("t4 resume", {31'd0, pc_en}, 32'd1);
        tick(); mem_req = 1'b0; drain();

        // taken branch resolved in EX
        set_id(1, 1, 2, 3, 1, 1, 1, 0); ex_redirect = 1'b1;
        @(negedge clk);
        chk("t3 flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        tick(); ex_redirect = 1'b0; nop();
        @(negedge clk);
        chk("t3 flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
        tick();

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            set_id(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
            ex_redirect = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 9) < 4);
            mem_ready   = ($urandom_range(0, 9) < 6);
            reset       = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
